// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the debounced outputs.
// The conditioner takes the slave side; whoever drives the pins takes master.
interface button_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] BUTTON_RAW;
    logic [NUM_BTN-1:0] BTN_LEVEL;
    logic [NUM_BTN-1:0] BTN_PRESS;
    logic [NUM_BTN-1:0] BTN_RELEASE;

    modport master (
        output BUTTON_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE
    );

    modport slave (
        input  BUTTON_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser + debounce FSM producing level, press and release pulses.
// Define AUTOREPEAT_EN to add repeated press pulses while a button is held.
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int REPEAT_DELAY    = 62_500_000,
    parameter int REPEAT_RATE     = 12_500_000
) (
    input  logic                   clk,
    input  logic                   rst,
    button_conditioner_if.slave    btn,
    output logic [2*NUM_BTN-1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);
`endif

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("button_conditioner: invalid timing parameters");
    end

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] release_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn.BUTTON_RAW;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_e          state_q, state_d;
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            in_s;

        assign in_s = sync2_q[g];

`ifdef AUTOREPEAT_EN
        logic [RP_W-1:0] rcnt_q, rcnt_d;
        logic            rpt_q, rpt_d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rcnt_q <= '0;
                rpt_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rpt_q  <= rpt_d;
            end
        end
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_s) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!in_s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!in_s) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (in_s) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

`ifdef AUTOREPEAT_EN
            // Repeat timing only advances while staying in PRESSED; any entry restarts the delay.
            rcnt_d = rcnt_q;
            rpt_d  = rpt_q;
            if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
                if (!rpt_q && rcnt_q == RP_DELAY_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    rpt_d   = 1'b1;
                end else if (rpt_q && rcnt_q == RP_RATE_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RP_W'(1);
                end
            end else begin
                rcnt_d = '0;
                rpt_d  = 1'b0;
            end
`endif

            level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        end

        assign level_vec[g]           = level_q;
        assign press_vec[g]           = press_q;
        assign release_vec[g]         = release_q;
        assign dbg_state_o[2*g +: 2]  = state_q;
    end

    assign btn.BTN_LEVEL   = level_vec;
    assign btn.BTN_PRESS   = press_vec;
    assign btn.BTN_RELEASE = release_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and timings.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2*N-1:0] dbg_state;

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(N)) bif ();

    button_conditioner #(
        .NUM_BTN        (N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (bif),
        .dbg_state_o(dbg_state)
    );

    int tests  = 0;
    int errors = 0;

    task automatic chk_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an output level flips once the synchronised input has disagreed with
    // it for DB+1 consecutive clock edges; the input seen is two edges old.
    logic [N-1:0] hist[$];
    logic [N-1:0] vis;
    logic [N-1:0] m_lvl   = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    int           m_run[N];
    int           m_held[N];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
        end else begin
            vis = (hist.size() == 2) ? hist[0] : '0;
            hist.push_back(bif.BUTTON_RAW);
            if (hist.size() > 2) void'(hist.pop_front());
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < N; c++) begin
                if (vis[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_lvl[c]  = ~m_lvl[c];
                        m_run[c]  = 0;
                        m_held[c] = 0;
                        if (m_lvl[c]) m_press[c] = 1'b1;
                        else          m_rel[c]   = 1'b1;
                    end
                end else begin
                    if (m_lvl[c] && m_run[c] == 0) begin
                        m_held[c]++;
`ifdef AUTOREPEAT_EN
                        if (m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0) m_press[c] = 1'b1;
`endif
                    end else begin
                        m_held[c] = 0;
                    end
                    m_run[c] = 0;
                end
            end
        end
    end

    // Event counters driven from DUT outputs, pinned by literal checks per scenario.
    int n_press0 = 0, n_rel0 = 0, n_rise0 = 0, n_fall0 = 0;
    int n_press1 = 0, n_rel1 = 0;
    logic prev_lvl0 = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk_vec("model_level",   bif.BTN_LEVEL,   m_lvl);
            chk_vec("model_press",   bif.BTN_PRESS,   m_press);
            chk_vec("model_release", bif.BTN_RELEASE, m_rel);
            if (bif.BTN_PRESS[0])   n_press0++;
            if (bif.BTN_RELEASE[0]) n_rel0++;
            if (bif.BTN_PRESS[1])   n_press1++;
            if (bif.BTN_RELEASE[1]) n_rel1++;
            if (bif.BTN_LEVEL[0] && !prev_lvl0) n_rise0++;
            if (!bif.BTN_LEVEL[0] && prev_lvl0) n_fall0++;
            prev_lvl0 = bif.BTN_LEVEL[0];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        n_press0 = 0; n_rel0 = 0; n_rise0 = 0; n_fall0 = 0;
        n_press1 = 0; n_rel1 = 0;
    endtask

    initial begin
        bif.BUTTON_RAW = 2'b11;

        // Scenario 1: reset with both held, then press after 6 edges
        step(2);
        chk_vec("rst_level",   bif.BTN_LEVEL,   2'b00);
        chk_vec("rst_press",   bif.BTN_PRESS,   2'b00);
        chk_vec("rst_release", bif.BTN_RELEASE, 2'b00);
        rst = 1'b1;
        step(6);
        chk_vec("s1_press_early", bif.BTN_PRESS, 2'b00);
        chk_vec("s1_level_early", bif.BTN_LEVEL, 2'b00);
        step(1);
        chk_vec("s1_press_edge6", bif.BTN_PRESS, 2'b11);
        chk_vec("s1_level_edge6", bif.BTN_LEVEL, 2'b11);
        step(1);
        chk_vec("s1_press_one_cycle", bif.BTN_PRESS, 2'b00);
        chk_vec("s1_level_held",      bif.BTN_LEVEL, 2'b11);

        // Scenario 2: 3-cycle pulse rejected
        bif.BUTTON_RAW = 2'b00;
        step(12);
        clear_counts();
        bif.BUTTON_RAW = 2'b01;
        step(3);
        bif.BUTTON_RAW = 2'b00;
        step(10);
        chk_int("s2_press0", n_press0, 0);
        chk_int("s2_rel0",   n_rel0,   0);
        chk_int("s2_rise0",  n_rise0,  0);

        // Scenario 3: held press with a 2-cycle low glitch
        clear_counts();
        bif.BUTTON_RAW = 2'b01;
        step(20);
        bif.BUTTON_RAW = 2'b00;
        step(2);
        bif.BUTTON_RAW = 2'b01;
        step(10);
        chk_int("s3_fall0_during_glitch", n_fall0, 0);
        bif.BUTTON_RAW = 2'b00;
        step(10);
        chk_int("s3_rel0",  n_rel0,  1);
        chk_int("s3_rise0", n_rise0, 1);
        chk_int("s3_fall0", n_fall0, 1);
`ifndef AUTOREPEAT_EN
        chk_int("s3_press0", n_press0, 1);
`endif

        // Scenario 4: press on ch0 and release on ch1 at the same time
        bif.BUTTON_RAW = 2'b10;
        step(10);
        clear_counts();
        bif.BUTTON_RAW = 2'b01;
        step(6);
        chk_vec("s4_press_early",   bif.BTN_PRESS,   2'b00);
        chk_vec("s4_release_early", bif.BTN_RELEASE, 2'b00);
        step(1);
        chk_vec("s4_press_aligned",   bif.BTN_PRESS,   2'b01);
        chk_vec("s4_release_aligned", bif.BTN_RELEASE, 2'b10);
        chk_vec("s4_level",           bif.BTN_LEVEL,   2'b01);
        step(10);
        chk_int("s4_press1", n_press1, 0);
        chk_int("s4_rel0",   n_rel0,   0);

        // Scenario 5: reset mid-debounce and mid-press
        bif.BUTTON_RAW = 2'b00;
        step(10);
        clear_counts();
        bif.BUTTON_RAW = 2'b01;
        step(4);
        rst = 1'b0;
        #1;
        chk_vec("s5_rst_pw_level", bif.BTN_LEVEL, 2'b00);
        chk_vec("s5_rst_pw_press", bif.BTN_PRESS, 2'b00);
        step(2);
        rst = 1'b1;
        step(6);
        chk_vec("s5_repress_early", bif.BTN_PRESS, 2'b00);
        step(1);
        chk_vec("s5_repress_edge6", bif.BTN_PRESS, 2'b01);
        chk_vec("s5_relevel",       bif.BTN_LEVEL, 2'b01);
        step(3);
        rst = 1'b0;
        #1;
        chk_vec("s5_rst_pressed_level",   bif.BTN_LEVEL,   2'b00);
        chk_vec("s5_rst_pressed_release", bif.BTN_RELEASE, 2'b00);
        step(2);
        rst = 1'b1;
        step(7);
        chk_vec("s5_repress2_edge6", bif.BTN_PRESS, 2'b01);
        chk_vec("s5_relevel2",       bif.BTN_LEVEL, 2'b01);
        step(5);
        chk_int("s5_rel0",   n_rel0,   0);
        chk_int("s5_press0", n_press0, 2);

        // Scenario 6: long hold, auto-repeat pulses only when enabled
        bif.BUTTON_RAW = 2'b00;
        step(12);
        clear_counts();
        bif.BUTTON_RAW = 2'b01;
        step(40);
        bif.BUTTON_RAW = 2'b00;
        step(12);
`ifdef AUTOREPEAT_EN
        chk_int("s6_press0_repeat", n_press0, 10);
`else
        chk_int("s6_press0_single", n_press0, 1);
`endif
        chk_int("s6_rel0", n_rel0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
